// File: rtl/sd_data_tx_serializer_pkg.sv
// ---------------------------------------------------------------------------
// sd_data_tx_serializer_pkg
// Shared constants and types for the SD DAT write-block serializer:
//   - CRC16-CCITT polynomial and a serial single-bit update helper
//   - CRC-status token that the card returns for a good block
//   - default status-token timeout
//   - serializer state encoding
// ---------------------------------------------------------------------------
package sd_data_tx_serializer_pkg;

    localparam logic [15:0] CRC16_POLY        = 16'h1021;
    localparam logic [2:0]  STATUS_TOKEN_OK   = 3'b010;
    localparam int          STATUS_TO_DEFAULT = 64;
    localparam logic [3:0]  DAT_IDLE          = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_STOP,
        ST_TURN,
        ST_STATUS,
        ST_BUSYW
    } tx_state_t;

    // One serial CRC16 step, MSB-first, polynomial x^16+x^12+x^5+1.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
        crc16_next = {crc[14:0], 1'b0} ^ (((din ^ crc[15]) == 1'b1) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_tx_crc16.sv
// ---------------------------------------------------------------------------
// sd_tx_crc16
// Serial CRC16-CCITT accumulator for one DAT line, one bit per clock.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (CRC -> 0)
//   clr    in   synchronous clear to 0 (start of a block); wins over en
//   en     in   fold din into the CRC this cycle
//   din    in   data bit as driven on the line
//   crc    out  running CRC value
// ---------------------------------------------------------------------------
module sd_tx_crc16
    import sd_data_tx_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_next(crc, din);
        end
    end

endmodule

// File: rtl/sd_data_tx_serializer.sv
// ---------------------------------------------------------------------------
// sd_data_tx_serializer
// Pops 32-bit words from the TX FIFO and drives one SD write data block on
// DAT (start bit, payload MSB first, per-line CRC16, end bit), then collects
// the card's 3-bit CRC-status token and waits out busy on DAT0.
//   sd_clk      in   clock, all logic on posedge
//   rst_n       in   asynchronous active-low reset
//   start_tx    in   pulse: send one block (ignored unless idle)
//   abort       in   level: drop the transfer, return to idle, no done
//   bus_4bit    in   1 = DAT[3:0], 0 = DAT0 only (latched on start_tx)
//   blk_len     in   block bytes, multiple of 4 (latched on start_tx)
//   fifo_dat    in   TX FIFO head word
//   fifo_empty  in   TX FIFO empty
//   fifo_rd     out  one-cycle pop request
//   dat_o       out  DAT drive value
//   dat_oe      out  DAT output enable
//   dat_i       in   DAT pad input (only DAT0 used)
//   busy        out  transfer in progress
//   done        out  one-cycle block-finished pulse
//   crc_ok      out  valid with done: card returned the OK token
//   underrun    out  sticky: FIFO ran dry mid-payload
// All outputs are registered; each edge computes the value for the state
// being entered, so e.g. the start bit is on DAT while state is ST_START.
// ---------------------------------------------------------------------------
module sd_data_tx_serializer
    import sd_data_tx_serializer_pkg::*;
#(
    parameter int STATUS_TO = STATUS_TO_DEFAULT,
    parameter int BLK_W     = 12
) (
    input  logic             sd_clk,
    input  logic             rst_n,
    input  logic             start_tx,
    input  logic             abort,
    input  logic             bus_4bit,
    input  logic [BLK_W-1:0] blk_len,
    input  logic [31:0]      fifo_dat,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    output logic [3:0]       dat_o,
    output logic             dat_oe,
    input  logic [3:0]       dat_i,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             underrun
);

    localparam int WC_W = BLK_W - 2;
    localparam int TO_W = $clog2(STATUS_TO) + 1;

    tx_state_t         state_reg;
    logic [31:0]       sr_reg;
    logic [4:0]        bit_cnt_reg;    // chunk index in word / CRC index / turn and token count
    logic [WC_W-1:0]   word_cnt_reg;   // words still to load after the current one
    logic [TO_W-1:0]   tmo_cnt_reg;
    logic [2:0]        token_reg;
    logic              got_start_reg;
    logic              bus4_reg;

    logic [4:0]        last_chunk;
    logic              word_done;
    logic              more_words;
    logic [31:0]       src_word;
    logic [31:0]       src_shift;
    logic [3:0]        payload_chunk;
    logic [3:0]        crc_sel;
    logic [3:0]        crc_bits;
    logic [3:0]        crc_chunk;
    logic              crc_clr;
    logic              crc_en;
    logic [15:0]       crc_q [4];

    logic              unused_inputs;
    assign unused_inputs = &{1'b0, blk_len[1:0], dat_i[3:1]};

    always_comb begin
        last_chunk    = bus4_reg ? 5'd7 : 5'd31;
        word_done     = (bit_cnt_reg == last_chunk);
        more_words    = (word_cnt_reg != '0);
        // At a word boundary the next chunk comes straight from the FIFO head,
        // which keeps the payload seamless across words.
        src_word      = (state_reg == ST_DATA && word_done) ? fifo_dat : sr_reg;
        payload_chunk = bus4_reg ? src_word[31:28] : {3'b111, src_word[31]};
        src_shift     = bus4_reg ? {src_word[27:0], 4'h0} : {src_word[30:0], 1'b0};
        // Entering CRC emits bit 15; each CRC-state edge emits the next lower bit.
        crc_sel       = (state_reg == ST_CRC) ? (4'd14 - bit_cnt_reg[3:0]) : 4'd15;
        crc_chunk     = bus4_reg ? crc_bits : {3'b111, crc_bits[0]};
        crc_clr       = !abort && state_reg == ST_WAIT_DATA && !fifo_empty;
        crc_en        = !abort && (state_reg == ST_START ||
                        (state_reg == ST_DATA && (!word_done || (more_words && !fifo_empty))));
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_crc
            sd_tx_crc16 u_crc (
                .clk   (sd_clk),
                .rst_n (rst_n),
                .clr   (crc_clr),
                .en    (crc_en),
                .din   (payload_chunk[gi]),
                .crc   (crc_q[gi])
            );
            assign crc_bits[gi] = crc_q[gi][crc_sel];
        end
    endgenerate

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            sr_reg        <= '0;
            bit_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            token_reg     <= '0;
            got_start_reg <= 1'b0;
            bus4_reg      <= 1'b0;
            fifo_rd       <= 1'b0;
            dat_o         <= DAT_IDLE;
            dat_oe        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            crc_ok        <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            fifo_rd <= 1'b0;
            done    <= 1'b0;
            if (state_reg != ST_IDLE && abort) begin
                state_reg <= ST_IDLE;
                dat_oe    <= 1'b0;
                dat_o     <= DAT_IDLE;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_tx && !abort) begin
                            bus4_reg     <= bus_4bit;
                            word_cnt_reg <= blk_len[BLK_W-1:2] - WC_W'(1);
                            underrun     <= 1'b0;
                            crc_ok       <= 1'b0;
                            busy         <= 1'b1;
                            state_reg    <= ST_WAIT_DATA;
                        end
                    end
                    ST_WAIT_DATA: begin
                        if (!fifo_empty) begin
                            sr_reg    <= fifo_dat;
                            fifo_rd   <= 1'b1;
                            dat_oe    <= 1'b1;
                            dat_o     <= bus4_reg ? 4'h0 : 4'hE;
                            state_reg <= ST_START;
                        end
                    end
                    ST_START: begin
                        dat_o       <= payload_chunk;
                        sr_reg      <= src_shift;
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (!word_done) begin
                            dat_o       <= payload_chunk;
                            sr_reg      <= src_shift;
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end else if (!more_words) begin
                            dat_o       <= crc_chunk;
                            bit_cnt_reg <= '0;
                            state_reg   <= ST_CRC;
                        end else if (fifo_empty) begin
                            underrun  <= 1'b1;
                            dat_oe    <= 1'b0;
                            dat_o     <= DAT_IDLE;
                            done      <= 1'b1;
                            crc_ok    <= 1'b0;
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            dat_o        <= payload_chunk;
                            sr_reg       <= src_shift;
                            bit_cnt_reg  <= '0;
                            word_cnt_reg <= word_cnt_reg - WC_W'(1);
                            fifo_rd      <= 1'b1;
                        end
                    end
                    ST_CRC: begin
                        if (bit_cnt_reg == 5'd15) begin
                            dat_o     <= DAT_IDLE;
                            state_reg <= ST_STOP;
                        end else begin
                            dat_o       <= crc_chunk;
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                    ST_STOP: begin
                        dat_oe      <= 1'b0;
                        dat_o       <= DAT_IDLE;
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_TURN;
                    end
                    ST_TURN: begin
                        if (bit_cnt_reg == 5'd1) begin
                            tmo_cnt_reg   <= '0;
                            got_start_reg <= 1'b0;
                            state_reg     <= ST_STATUS;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                    ST_STATUS: begin
                        if (!got_start_reg) begin
                            if (!dat_i[0]) begin
                                got_start_reg <= 1'b1;
                                bit_cnt_reg   <= '0;
                            end else if (tmo_cnt_reg == TO_W'(STATUS_TO - 1)) begin
                                done      <= 1'b1;
                                crc_ok    <= 1'b0;
                                busy      <= 1'b0;
                                state_reg <= ST_IDLE;
                            end else begin
                                tmo_cnt_reg <= tmo_cnt_reg + TO_W'(1);
                            end
                        end else begin
                            // Three token bits, then the end bit is skipped.
                            if (bit_cnt_reg < 5'd3) begin
                                token_reg <= {token_reg[1:0], dat_i[0]};
                            end else begin
                                state_reg <= ST_BUSYW;
                            end
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                    ST_BUSYW: begin
                        if (dat_i[0]) begin
                            done      <= 1'b1;
                            crc_ok    <= (token_reg == STATUS_TOKEN_OK);
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
